// File: rtl/wb_queue.sv
// Write-back queue: buffers ALU and load results in order and retires one per cycle
// to the register-file write port, with a combinational forwarding lookup over queued entries.
`timescale 1ns/1ps
module wb_queue #(
   parameter int DATA_W           = 32,
   parameter int ADDR_W           = 5,
   parameter int DEPTH            = 4,
   parameter bit ZERO_REG_DISCARD = 1'b1
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         alu_valid,
   input  logic [ADDR_W-1:0]            alu_dreg,
   input  logic [DATA_W-1:0]            alu_data,
   input  logic                         mem_valid,
   input  logic [ADDR_W-1:0]            mem_dreg,
   input  logic [DATA_W-1:0]            mem_data,
   input  logic                         stall_in,
   output logic                         in_ready,
   output logic                         reg_wr,
   output logic [ADDR_W-1:0]            reg_add,
   output logic [DATA_W-1:0]            reg_data,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty,
   output logic                         full,
   output logic                         overflow,
   input  logic [ADDR_W-1:0]            fwd_add,
   output logic                         fwd_hit,
   output logic [DATA_W-1:0]            fwd_data
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [ADDR_W-1:0] dreg_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];

   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              reg_wr_q, reg_wr_d;
   logic [ADDR_W-1:0] reg_add_q, reg_add_d;
   logic [DATA_W-1:0] reg_data_q, reg_data_d;

   logic              mem_keep_s, alu_keep_s;
   logic              mem_push_s, alu_push_s;
   logic              pop_s, drop_s;
   logic [CNT_W-1:0]  free_s, n_push_s;
   logic [PTR_W-1:0]  alu_slot_s;

   logic              fwd_hit_s;
   logic [DATA_W-1:0] fwd_data_s;
   logic [PTR_W-1:0]  fwd_idx_s;
   logic              fwd_match_s;

   // Admission, drop detection and next-state pointer/count arithmetic.
   always_comb begin
      mem_keep_s = mem_valid && !(ZERO_REG_DISCARD && (mem_dreg == {ADDR_W{1'b0}}));
      alu_keep_s = alu_valid && !(ZERO_REG_DISCARD && (alu_dreg == {ADDR_W{1'b0}}));
      free_s     = CNT_W'(DEPTH) - count_q;
      // mem is the older of a simultaneous pair, so it claims the first free slot
      mem_push_s = mem_keep_s && (free_s >= CNT_W'(1));
      alu_push_s = alu_keep_s && (free_s >= (mem_push_s ? CNT_W'(2) : CNT_W'(1)));
      drop_s     = (mem_keep_s && !mem_push_s) || (alu_keep_s && !alu_push_s);
      n_push_s   = CNT_W'(mem_push_s) + CNT_W'(alu_push_s);
      pop_s      = (count_q != {CNT_W{1'b0}}) && !stall_in;
      alu_slot_s = mem_push_s ? (tail_q + PTR_W'(1)) : tail_q;
      tail_d     = tail_q + PTR_W'(n_push_s);
      head_d     = pop_s ? (head_q + PTR_W'(1)) : head_q;
      count_d    = count_q + n_push_s - CNT_W'(pop_s);
      overflow_d = overflow_q | drop_s;
      reg_wr_d   = pop_s;
      reg_add_d  = pop_s ? dreg_q[head_q] : reg_add_q;
      reg_data_d = pop_s ? data_q[head_q] : reg_data_q;
   end

   // Control state and registered write-port outputs.
   always_ff @(negedge clock or posedge reset) begin
      if (reset) begin
         head_q     <= {PTR_W{1'b0}};
         tail_q     <= {PTR_W{1'b0}};
         count_q    <= {CNT_W{1'b0}};
         overflow_q <= 1'b0;
         reg_wr_q   <= 1'b0;
         reg_add_q  <= {ADDR_W{1'b0}};
         reg_data_q <= {DATA_W{1'b0}};
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         reg_wr_q   <= reg_wr_d;
         reg_add_q  <= reg_add_d;
         reg_data_q <= reg_data_d;
      end
   end

   // Entry storage; validity is carried entirely by head/count, so no reset needed.
   always_ff @(negedge clock) begin
      if (mem_push_s) begin
         dreg_q[tail_q] <= mem_dreg;
         data_q[tail_q] <= mem_data;
      end
      if (alu_push_s) begin
         dreg_q[alu_slot_s] <= alu_dreg;
         data_q[alu_slot_s] <= alu_data;
      end
   end

   // Forwarding: scan oldest to youngest so the youngest match overrides.
   always_comb begin
      fwd_hit_s   = 1'b0;
      fwd_data_s  = {DATA_W{1'b0}};
      fwd_idx_s   = {PTR_W{1'b0}};
      fwd_match_s = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_idx_s   = head_q + PTR_W'(i);
         fwd_match_s = (CNT_W'(i) < count_q) && (dreg_q[fwd_idx_s] == fwd_add);
         fwd_hit_s   = fwd_hit_s | fwd_match_s;
         fwd_data_s  = fwd_match_s ? data_q[fwd_idx_s] : fwd_data_s;
      end
      if (ZERO_REG_DISCARD && (fwd_add == {ADDR_W{1'b0}})) begin
         fwd_hit_s  = 1'b0;
         fwd_data_s = {DATA_W{1'b0}};
      end else begin
         fwd_hit_s  = fwd_hit_s;
         fwd_data_s = fwd_data_s;
      end
   end

   assign in_ready = (count_q <= CNT_W'(DEPTH - 2));
   assign reg_wr   = reg_wr_q;
   assign reg_add  = reg_add_q;
   assign reg_data = reg_data_q;
   assign count    = count_q;
   assign empty    = (count_q == {CNT_W{1'b0}});
   assign full     = (count_q == CNT_W'(DEPTH));
   assign overflow = overflow_q;
   assign fwd_hit  = fwd_hit_s;
   assign fwd_data = fwd_data_s;

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: one instance discards register 0, a second treats it as ordinary.
`timescale 1ns/1ps
module tb_wb_queue;

   logic        clock, reset;
   logic        alu_valid, mem_valid, stall_in;
   logic [4:0]  alu_dreg, mem_dreg, fwd_add;
   logic [31:0] alu_data, mem_data;

   logic        in_ready, reg_wr, empty, full, overflow, fwd_hit;
   logic [4:0]  reg_add;
   logic [31:0] reg_data, fwd_data;
   logic [2:0]  count;

   logic        z_in_ready, z_reg_wr, z_empty, z_full, z_overflow, z_fwd_hit;
   logic [4:0]  z_reg_add;
   logic [31:0] z_reg_data, z_fwd_data;
   logic [2:0]  z_count;

   int n_vec = 0;
   int n_err = 0;

   wb_queue #(.DATA_W(32), .ADDR_W(5), .DEPTH(4), .ZERO_REG_DISCARD(1'b1)) dut (
      .clock(clock), .reset(reset),
      .alu_valid(alu_valid), .alu_dreg(alu_dreg), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_dreg(mem_dreg), .mem_data(mem_data),
      .stall_in(stall_in), .in_ready(in_ready),
      .reg_wr(reg_wr), .reg_add(reg_add), .reg_data(reg_data),
      .count(count), .empty(empty), .full(full), .overflow(overflow),
      .fwd_add(fwd_add), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
   );

   wb_queue #(.DATA_W(32), .ADDR_W(5), .DEPTH(4), .ZERO_REG_DISCARD(1'b0)) dut_z (
      .clock(clock), .reset(reset),
      .alu_valid(alu_valid), .alu_dreg(alu_dreg), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_dreg(mem_dreg), .mem_data(mem_data),
      .stall_in(stall_in), .in_ready(z_in_ready),
      .reg_wr(z_reg_wr), .reg_add(z_reg_add), .reg_data(z_reg_data),
      .count(z_count), .empty(z_empty), .full(z_full), .overflow(z_overflow),
      .fwd_add(fwd_add), .fwd_hit(z_fwd_hit), .fwd_data(z_fwd_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
      end
   endtask

   // Advance through one falling (active) edge and settle.
   task automatic step();
      @(negedge clock);
      #1;
   endtask

   task automatic drive(input logic mv, input logic [4:0] md, input logic [31:0] mdat,
                        input logic av, input logic [4:0] ad, input logic [31:0] adat);
      mem_valid = mv; mem_dreg = md; mem_data = mdat;
      alu_valid = av; alu_dreg = ad; alu_data = adat;
   endtask

   initial begin
      reset = 1'b1; stall_in = 1'b0; fwd_add = 5'd0;
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      #12;
      chk("rst_count", count, 3'd0);
      chk("rst_empty", empty, 1'b1);
      chk("rst_full", full, 1'b0);
      chk("rst_reg_wr", reg_wr, 1'b0);
      chk("rst_reg_add", reg_add, 5'd0);
      chk("rst_reg_data", reg_data, 32'h0);
      chk("rst_overflow", overflow, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      #3 reset = 1'b0;
      #3;

      // single ALU result, one-cycle latency, then hold
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h11);
      step();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      chk("t1_count1", count, 3'd1);
      chk("t1_no_wr", reg_wr, 1'b0);
      fwd_add = 5'd3; #1;
      chk("t1_fwd_hit", fwd_hit, 1'b1);
      chk("t1_fwd_data", fwd_data, 32'h11);
      step();
      chk("t1_wr", reg_wr, 1'b1);
      chk("t1_add", reg_add, 5'd3);
      chk("t1_data", reg_data, 32'h11);
      chk("t1_fwd_retired", fwd_hit, 1'b0);
      step();
      chk("t1_wr_off", reg_wr, 1'b0);
      chk("t1_add_hold", reg_add, 5'd3);
      chk("t1_data_hold", reg_data, 32'h11);

      // simultaneous mem+alu: mem is older
      drive(1'b1, 5'd5, 32'hAA, 1'b1, 5'd6, 32'hBB);
      step();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      chk("t2_count2", count, 3'd2);
      step();
      chk("t2_wr1", reg_wr, 1'b1);
      chk("t2_add1", reg_add, 5'd5);
      chk("t2_data1", reg_data, 32'hAA);
      chk("t2_count1", count, 3'd1);
      step();
      chk("t2_wr2", reg_wr, 1'b1);
      chk("t2_add2", reg_add, 5'd6);
      chk("t2_data2", reg_data, 32'hBB);
      chk("t2_count0", count, 3'd0);

      // stall fill, full, drop, then drain
      stall_in = 1'b1;
      drive(1'b1, 5'd1, 32'h10, 1'b1, 5'd2, 32'h20);
      step();
      chk("t3_count2", count, 3'd2);
      chk("t3_ready2", in_ready, 1'b1);
      chk("t3_stall_no_wr", reg_wr, 1'b0);
      drive(1'b1, 5'd3, 32'h30, 1'b1, 5'd4, 32'h40);
      step();
      chk("t3_full", full, 1'b1);
      chk("t3_ready0", in_ready, 1'b0);
      chk("t3_count4", count, 3'd4);
      chk("t3_ovf0", overflow, 1'b0);
      drive(1'b1, 5'd8, 32'h80, 1'b1, 5'd9, 32'h90);
      step();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      chk("t3_count_hold", count, 3'd4);
      chk("t3_ovf1", overflow, 1'b1);
      fwd_add = 5'd9; #1;
      chk("t3_fwd_dropped", fwd_hit, 1'b0);
      fwd_add = 5'd4; #1;
      chk("t3_fwd_r4", fwd_data, 32'h40);
      stall_in = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         step();
         chk("t3_drain_wr", reg_wr, 1'b1);
         chk("t3_drain_add", reg_add, 5'(i));
         chk("t3_drain_data", reg_data, 32'(i * 16));
      end
      chk("t3_empty", empty, 1'b1);
      step();
      chk("t3_idle_wr", reg_wr, 1'b0);
      chk("t3_ovf_sticky", overflow, 1'b1);

      // forwarding, youngest wins
      stall_in = 1'b1;
      drive(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2);
      step();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      fwd_add = 5'd7; #1;
      chk("t5_hit", fwd_hit, 1'b1);
      chk("t5_young", fwd_data, 32'h2);
      fwd_add = 5'd9; #1;
      chk("t5_miss_hit", fwd_hit, 1'b0);
      chk("t5_miss_data", fwd_data, 32'h0);

      // push and pop together to reach count 3 with a write in flight, then async reset
      stall_in = 1'b0;
      drive(1'b1, 5'd10, 32'h33, 1'b1, 5'd11, 32'h44);
      step();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      stall_in = 1'b1;
      chk("t6_count3", count, 3'd3);
      chk("t6_wr_r7", reg_wr, 1'b1);
      chk("t6_data_r7", reg_data, 32'h1);
      #2 reset = 1'b1;
      #1;
      chk("t6_rst_count", count, 3'd0);
      chk("t6_rst_empty", empty, 1'b1);
      chk("t6_rst_wr", reg_wr, 1'b0);
      chk("t6_rst_ovf", overflow, 1'b0);
      #1 reset = 1'b0;
      stall_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t6_no_stale", reg_wr, 1'b0);
      end

      // register 0: discarded on dut, retired on dut_z
      fwd_add = 5'd0;
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55);
      step();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      chk("t4_count", count, 3'd0);
      chk("t4_z_count", z_count, 3'd1);
      chk("t4_fwd0", fwd_hit, 1'b0);
      chk("t4_z_fwd0", z_fwd_data, 32'h55);
      step();
      chk("t4_no_wr", reg_wr, 1'b0);
      chk("t4_z_wr", z_reg_wr, 1'b1);
      chk("t4_z_add", z_reg_add, 5'd0);
      chk("t4_z_data", z_reg_data, 32'h55);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
